// File: rtl/keccak_pkg.sv
// Shared constants, mode encoding and FSM state type for the Keccak message padder.
package keccak_pkg;

    localparam logic [7:0] DS_SHA3   = 8'h06;
    localparam logic [7:0] DS_SHAKE  = 8'h1F;
    localparam logic [7:0] DS_KECCAK = 8'h01;
    localparam logic [7:0] PAD_FINAL = 8'h80;

    typedef enum logic [1:0] {
        MODE_SHA3   = 2'b00,
        MODE_SHAKE  = 2'b01,
        MODE_KECCAK = 2'b10,
        MODE_RSVD   = 2'b11
    } pad_mode_e;

    typedef enum logic {
        ST_ACCEPT = 1'b0,
        ST_FULL   = 1'b1
    } pad_state_e;

    // The reserved encoding falls back to SHA3 so a bad mode still yields a valid digest pad.
    function automatic logic [7:0] domain_byte(input logic [1:0] mode);
        logic [7:0] ds;
        case (pad_mode_e'(mode))
            MODE_SHAKE:  ds = DS_SHAKE;
            MODE_KECCAK: ds = DS_KECCAK;
            default:     ds = DS_SHA3;
        endcase
        return ds;
    endfunction

endpackage

// File: rtl/keccak_lastword_pad.sv
// Combinational last-word padder: keeps the first byte_num message bytes, inserts the
// domain-separation byte right after them and zeroes the rest of the word.
module keccak_lastword_pad #(
    parameter int IN_BYTES = 8
) (
    input  logic [8*IN_BYTES-1:0]         in_word,
    input  logic [$clog2(IN_BYTES)-1:0]   byte_num,
    input  logic [7:0]                    domain,
    output logic [8*IN_BYTES-1:0]         padded
);

    localparam int BN_W = $clog2(IN_BYTES);

    always_comb begin
        padded = '0;
        for (int b = 0; b < IN_BYTES; b++) begin
            if (BN_W'(b) < byte_num) begin
                padded[8*(IN_BYTES-1-b) +: 8] = in_word[8*(IN_BYTES-1-b) +: 8];
            end else if (BN_W'(b) == byte_num) begin
                padded[8*(IN_BYTES-1-b) +: 8] = domain;
            end
        end
    end

endmodule

// File: rtl/keccak_padder_param.sv
// Keccak/SHA-3 rate-block assembler with domain byte and final 0x80 pad bit.
// Define PADDER_MODE_SEL_EN to decode the mode port; otherwise the domain byte is fixed to SHA3.
module keccak_padder_param
    import keccak_pkg::*;
#(
    parameter int RATE_BYTES = 72,
    parameter int IN_BYTES   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [8*IN_BYTES-1:0]         in,
    input  logic                          in_ready,
    input  logic                          is_last,
    input  logic [$clog2(IN_BYTES)-1:0]   byte_num,
    input  logic [1:0]                    mode,
    input  logic                          f_ack,
    output logic                          buffer_full,
    output logic [8*RATE_BYTES-1:0]       out,
    output logic                          out_ready
);

    localparam int WORD_W = 8 * IN_BYTES;
    localparam int BLK_W  = 8 * RATE_BYTES;
    localparam int SLOTS  = RATE_BYTES / IN_BYTES;
    localparam int IDX_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLOTS - 1);

    pad_state_e         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [BLK_W-1:0]   buf_q, buf_d;
    logic [7:0]         domain;
    logic [WORD_W-1:0]  pad_word;
    logic [WORD_W-1:0]  slot_word;
    logic               accept;
    logic               block_done;

`ifdef PADDER_MODE_SEL_EN
    assign domain = domain_byte(mode);
`else
    logic unused_mode;
    assign unused_mode = ^mode;
    assign domain      = DS_SHA3;
`endif

    keccak_lastword_pad #(
        .IN_BYTES (IN_BYTES)
    ) u_lastword_pad (
        .in_word  (in),
        .byte_num (byte_num),
        .domain   (domain),
        .padded   (pad_word)
    );

    assign accept     = in_ready && (state_q == ST_ACCEPT);
    assign block_done = is_last || (idx_q == LAST_IDX);
    assign slot_word  = is_last ? pad_word : in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_ACCEPT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCEPT: if (accept && block_done) state_d = ST_FULL;
            ST_FULL:   if (f_ack)                state_d = ST_ACCEPT;
            default:                             state_d = ST_ACCEPT;
        endcase
    end

    always_comb begin
        buffer_full = (state_q == ST_FULL);
        out_ready   = (state_q == ST_FULL);
    end

    // Clearing on ack is what keeps slots past the last word at zero in the next block.
    always_comb begin
        buf_d = buf_q;
        idx_d = idx_q;
        if (state_q == ST_FULL) begin
            if (f_ack) begin
                buf_d = '0;
            end
        end else if (accept) begin
            for (int s = 0; s < SLOTS; s++) begin
                if (idx_q == IDX_W'(s)) begin
                    buf_d[BLK_W-1-s*WORD_W -: WORD_W] = slot_word;
                end
            end
            if (is_last) begin
                buf_d[7:0] = buf_d[7:0] | PAD_FINAL;
            end
            idx_d = block_done ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_q <= '0;
            idx_q <= '0;
        end else begin
            buf_q <= buf_d;
            idx_q <= idx_d;
        end
    end

    assign out = buf_q;

endmodule

// File: tb/tb_keccak_padder_param.sv
// Scoreboard bench for keccak_padder_param: byte-level pad model feeds an expected-block queue.
module tb_keccak_padder_param;

    localparam int RB  = 72;
    localparam int IB  = 8;
    localparam int BNW = $clog2(IB);

    typedef logic [8*RB-1:0] blk_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [8*IB-1:0]   in_w = '0;
    logic              in_ready = 1'b0;
    logic              is_last = 1'b0;
    logic [BNW-1:0]    byte_num = '0;
    logic [1:0]        mode = 2'b00;
    logic              f_ack = 1'b0;
    logic              buffer_full;
    blk_t              out_w;
    logic              out_ready;

    blk_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    keccak_padder_param #(.RATE_BYTES(RB), .IN_BYTES(IB)) dut (
        .clk         (clk),
        .reset       (reset),
        .in          (in_w),
        .in_ready    (in_ready),
        .is_last     (is_last),
        .byte_num    (byte_num),
        .mode        (mode),
        .f_ack       (f_ack),
        .buffer_full (buffer_full),
        .out         (out_w),
        .out_ready   (out_ready)
    );

    task automatic check(input string name, input blk_t act, input blk_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] dom(input logic [1:0] m);
`ifdef PADDER_MODE_SEL_EN
        case (m)
            2'b01:   return 8'h1F;
            2'b10:   return 8'h01;
            default: return 8'h06;
        endcase
`else
        return (m == 2'b11) ? 8'h06 : 8'h06;
`endif
    endfunction

    // Standard multi-rate pad: msg || domain || 0* then OR 0x80 into the final byte.
    task automatic push_expected(input logic [7:0] msg[$], input logic [1:0] m);
        logic [7:0] p[$];
        p = msg;
        p.push_back(dom(m));
        while (p.size() % RB != 0) p.push_back(8'h00);
        p[p.size()-1] = p[p.size()-1] | 8'h80;
        for (int b = 0; b < p.size() / RB; b++) begin
            blk_t x;
            for (int k = 0; k < RB; k++) x[8*(RB-1-k) +: 8] = p[b*RB + k];
            exp_q.push_back(x);
        end
    endtask

    // Called and returns at a falling edge; junk is presented while the buffer is full.
    task automatic send_word(input logic [8*IB-1:0] w, input logic last,
                             input logic [BNW-1:0] bn, input logic [1:0] m);
        int guard = 0;
        while ($urandom_range(0, 3) == 0) begin
            in_ready = 1'b0;
            @(negedge clk);
        end
        while (buffer_full) begin
            in_ready = 1'($urandom_range(0, 1));
            in_w     = {$urandom, $urandom};
            is_last  = 1'($urandom_range(0, 1));
            byte_num = BNW'($urandom);
            mode     = 2'($urandom);
            @(negedge clk);
            guard++;
            if (guard > 500) begin
                miscompares++;
                $display("FAIL accept_timeout: buffer_full stuck at 1 want 0");
                $fatal(1, "padder stalled");
            end
        end
        in_w     = w;
        is_last  = last;
        byte_num = bn;
        mode     = m;
        in_ready = 1'b1;
        @(negedge clk);
        in_ready = 1'b0;
    endtask

    task automatic send_message(input logic [7:0] msg[$], input logic [1:0] m);
        int nfull = msg.size() / IB;
        int rem   = msg.size() % IB;
        logic [8*IB-1:0] wd;
        push_expected(msg, m);
        for (int w = 0; w < nfull; w++) begin
            for (int k = 0; k < IB; k++) wd[8*(IB-1-k) +: 8] = msg[w*IB + k];
            send_word(wd, 1'b0, BNW'($urandom), 2'($urandom));
        end
        wd = {$urandom, $urandom};
        for (int k = 0; k < rem; k++) wd[8*(IB-1-k) +: 8] = msg[nfull*IB + k];
        send_word(wd, 1'b1, BNW'(rem), m);
    endtask

    task automatic pattern_msg(input int len, output logic [7:0] msg[$]);
        logic [63:0] pat = 64'h90ABCDEF11111111;
        msg = {};
        for (int i = 0; i < len; i++) msg.push_back(pat[8*(7 - i % 8) +: 8]);
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (exp_q.size() != 0 || out_ready || f_ack) begin
            @(negedge clk);
            guard++;
            if (guard > 2000) begin
                miscompares++;
                $display("FAIL drain_timeout: %0d blocks outstanding want 0", exp_q.size());
                break;
            end
        end
    endtask

    // Monitor: compares each new block, checks hold stability, acks after a random wait.
    initial begin : monitor
        blk_t cur;
        bit   held = 1'b0;
        int   hold_cnt = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                held  = 1'b0;
                f_ack = 1'b0;
                continue;
            end
            check("full_eq_ready", blk_t'(buffer_full), blk_t'(out_ready));
            if (f_ack) begin
                check("ack_drops_ready", blk_t'(out_ready), '0);
                check("ack_clears_out", out_w, '0);
                f_ack = 1'b0;
                held  = 1'b0;
            end else if (out_ready) begin
                if (!held) begin
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_block: got %h want none", out_w);
                        cur = out_w;
                    end else begin
                        cur = exp_q.pop_front();
                        check("block", out_w, cur);
                    end
                    held     = 1'b1;
                    hold_cnt = $urandom_range(0, 6);
                end else begin
                    check("held_stable", out_w, cur);
                end
                if (hold_cnt == 0) f_ack = 1'b1;
                else hold_cnt--;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] msg[$];
        #1 reset = 1'b0;
        #2;
        check("rst_out", out_w, '0);
        check("rst_ready", blk_t'(out_ready), '0);
        check("rst_full", blk_t'(buffer_full), '0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        pattern_msg(1, msg);  send_message(msg, 2'b00);
        pattern_msg(72, msg); send_message(msg, 2'b00);
        pattern_msg(71, msg); send_message(msg, 2'b01);
        msg = {};             send_message(msg, 2'b01);
        msg = {};             send_message(msg, 2'b10);

        for (int n = 0; n < 40; n++) begin
            int len = $urandom_range(0, 230);
            msg = {};
            for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
            send_message(msg, 2'($urandom));
        end
        wait_idle();

        pattern_msg(24, msg);
        for (int w = 0; w < 3; w++) send_word({$urandom, $urandom}, 1'b0, '0, 2'b00);
        #2 reset = 1'b0;
        #1;
        check("midrst_out", out_w, '0);
        check("midrst_ready", blk_t'(out_ready), '0);
        check("midrst_full", blk_t'(buffer_full), '0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        msg = {};
        send_message(msg, 2'b00);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/keccak_padder_param.md
# keccak_padder_param

Parametrised Keccak/SHA-3 message padder: accepts a byte-stream message in IN_BYTES-wide words and assembles rate-sized blocks with the selectable domain-separation byte and the final 0x80 pad bit. It sits between the message source and the Keccak-f[1600] permutation core. It generalises the fixed 576-bit SHA3 padder to any rate/word ratio and to SHA3/SHAKE/Keccak modes.

## Interface
- RATE_BYTES, 72: block size in bytes (72/104/136/144/168). Must be a multiple of IN_BYTES.
- IN_BYTES, 8: input word width in bytes. Must be ≥2.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in  in  8*IN_BYTES  message word; first byte in in[8*IN_BYTES-1 -: 8].
- in_ready  in  1  word valid.
- is_last  in  1  word is the final, partial word of the message.
- byte_num  in  clog2(IN_BYTES)  valid bytes in the last word, 0..IN_BYTES-1; ignored when is_last=0.
- mode  in  2  00 SHA3 (0x06), 01 SHAKE (0x1F), 10 raw Keccak (0x01), 11 treated as 00.
- f_ack  in  1  consumer takes the block.
- buffer_full  out  1  word input blocked.
- out  out  8*RATE_BYTES  assembled block; byte 0 in MSBs, last byte in out[7:0].
- out_ready  out  1  out holds a complete block.

## Operation
- Reset values: out=0, out_ready=0, buffer_full=0, word index=0, state ACCEPT.
- States: ACCEPT, FULL.
- ACCEPT: a word is accepted on a rising edge with in_ready=1 and buffer_full=0. It is written at word index idx, MSB first. idx counts 0..RATE_BYTES/IN_BYTES-1.
- Non-last word: idx increments. If idx was the final slot, the state goes to FULL and idx returns to 0.
- Last word: written bytes are bytes 0..byte_num-1 of in, then the domain byte at byte_num, then zeros. Byte RATE_BYTES-1 of the block is ORed with 0x80; if the domain byte lands there, that byte becomes domain|0x80. Unwritten slots stay 0, because the buffer is cleared on ack. The state goes to FULL and idx returns to 0.
- Message length is a multiple of IN_BYTES: the source sends a final word with is_last=1 and byte_num=0. That word may be the first word of a new block, giving a pure-pad block.
- FULL: out_ready=1 and buffer_full=1. in_ready and is_last are ignored. out is held stable.
- f_ack=1 while in FULL: buffer cleared to 0, state returns to ACCEPT. f_ack is ignored in ACCEPT.
- Mode is sampled with the last word only. Changing mode mid-message is legal, and only the value sampled with the last word matters.
- Reset asserted mid-block discards the partial block immediately (asynchronously).

## Timing
- Latency: out_ready rises on the same edge that captures the last word of a block (visible one cycle after presentation).
- buffer_full and out_ready are registered and identical (both equal state==FULL).
- In the f_ack cycle buffer_full is still 1, so a word presented then is not taken. The earliest next accept is the cycle after.
- Throughput: one word per cycle, plus one ack cycle per block.

## Configuration
- PADDER_MODE_SEL_EN defined: mode port decoded as above.
- PADDER_MODE_SEL_EN not defined: mode ignored, domain byte fixed 0x06 (SHA3), decode logic removed. The port remains for pin compatibility.

## Structure
- Package keccak_pkg holds:
  - constants DS_SHA3=8'h06, DS_SHAKE=8'h1F, DS_KECCAK=8'h01, PAD_FINAL=8'h80;
  - the mode encoding;
  - the ACCEPT/FULL state enum.
- Sub-module keccak_lastword_pad is combinational: (in, byte_num, domain) -> padded word. The top module handles the buffer, index, FSM and the final 0x80 OR.

## Test plan
All scenarios use defaults RATE_BYTES=72, IN_BYTES=8.
1. One word 0x90ABCDEF11111111, is_last=1, byte_num=1, mode=00 -> next cycle out_ready=1, buffer_full=1, out=0x9006 followed by zeros ending in byte 0x80.
2. Nine non-last words 0x90ABCDEF11111111, then is_last=1 byte_num=0 -> block 1 = 9 repeats of the word; after f_ack, block 2 = 0x06, 70 zero bytes, 0x80.
3. Eight full words, then last word byte_num=7, mode=01 -> out[7:0]=0x9F, and the preceding 7 bytes equal the input bytes.
4. Block full, f_ack held 0 for 5 cycles while in_ready=1 -> buffer_full stays 1, out unchanged, no word lost. f_ack=1 -> out_ready=0 next cycle, out=0.
5. Reset pulled low after 3 accepted words -> out=0, out_ready=0, buffer_full=0. The following last word byte_num=0 yields 0x06..0x80 at index 0.
6. Build without PADDER_MODE_SEL_EN, mode=01, last word byte_num=0 -> domain byte is 0x06, not 0x1F.
